// File: rtl/array_17_port_driver.sv
// array_17_port_driver
// ---------------------------------------------------------------------------
// Requester-side controller for a 4096x80 single-port, byte-masked array with
// a 1-cycle registered-address read. Accepts read/write requests over a
// valid/ready channel, drives the array's RW0 port, and returns read data
// through a 3-entry in-order response FIFO with valid/ready backpressure.
//
// Ports:
//   clock        single clock (array RW0_clk is tied to the same net)
//   reset_n      asynchronous active-low reset
//   req_valid    request present
//   req_ready    request accepted this cycle when high together with req_valid
//   req_write    1 = write, 0 = read
//   req_addr     entry address
//   req_mask     byte write enables (ignored on reads)
//   req_data     write data
//   resp_valid   read response at FIFO head
//   resp_ready   consumer takes the head entry
//   resp_data    head read data
//   init_done    array usable
//   RW0_*        array port signals (addr/en/wmode/wmask/wdata out, rdata in)
//
// Configuration macro:
//   ARRAY_17_PORT_INIT_EN  when defined, the block zero-fills every array
//                          entry after reset before accepting any request.
// ---------------------------------------------------------------------------
module array_17_port_driver #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 80,
  parameter int MASK_W = 10,
  parameter int DEPTH  = 4096
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MASK_W-1:0] req_mask,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  // The init sweep walks every address exactly once, so the address width
  // must cover the entry count precisely.
  if (DEPTH != (1 << ADDR_W)) begin : gDepthCheck
    $error("array_17_port_driver: DEPTH must equal 2**ADDR_W");
  end

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t            state_q;
  logic              initDone_q;
  logic              inflight_q, inflight_d;
  logic [1:0]        count_q, count_d;
  logic [1:0]        wrPtr_q, wrPtr_d;
  logic [1:0]        rdPtr_q, rdPtr_d;
  logic [DATA_W-1:0] fifoMem_q [3];
`ifdef ARRAY_17_PORT_INIT_EN
  logic [ADDR_W-1:0] initAddr_q;
`endif

  logic [2:0] credits;
  logic       accept;
  logic       push;
  logic       pop;

  function automatic logic [1:0] nextPtr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credits cover both queued responses and the read whose data arrives next
  // cycle, so the FIFO can never overflow. Writes are held to the same limit
  // to keep req_ready independent of the request contents.
  always_comb begin
    credits    = {1'b0, count_q} + {2'b00, inflight_q};
    req_ready  = (state_q == RUN) && (credits < 3'd3);
    accept     = req_valid && req_ready;
    push       = inflight_q;
    resp_valid = (count_q != 2'd0);
    pop        = resp_valid && resp_ready;
    resp_data  = fifoMem_q[rdPtr_q];
    init_done  = initDone_q;
  end

  // Array port: request fields pass straight through; the enable is only
  // raised on an accepted request (or on every sweep cycle during init).
  always_comb begin
    RW0_en    = accept;
    RW0_wmode = req_write;
    RW0_addr  = req_addr;
    RW0_wmask = req_mask;
    RW0_wdata = req_data;
`ifdef ARRAY_17_PORT_INIT_EN
    // Gated by reset_n so the array sees no enable while reset is held.
    if (state_q == INIT) begin
      RW0_en    = reset_n;
      RW0_wmode = 1'b1;
      RW0_addr  = initAddr_q;
      RW0_wmask = '1;
      RW0_wdata = '0;
    end
`endif
  end

  // Next-state for the read pipeline and FIFO bookkeeping. A simultaneous
  // push and pop leaves the occupancy unchanged.
  always_comb begin
    inflight_d = accept && !req_write;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      count_d = count_q - 2'd1;
    end
    wrPtr_d = push ? nextPtr(wrPtr_q) : wrPtr_q;
    rdPtr_d = pop  ? nextPtr(rdPtr_q) : rdPtr_q;
  end

  // Control state. Reset discards queued responses and any read in flight;
  // with the init sweep enabled it restarts from address 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
`ifdef ARRAY_17_PORT_INIT_EN
      state_q    <= INIT;
      initDone_q <= 1'b0;
      initAddr_q <= '0;
`else
      state_q    <= RUN;
      initDone_q <= 1'b1;
`endif
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      wrPtr_q    <= 2'd0;
      rdPtr_q    <= 2'd0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
`ifdef ARRAY_17_PORT_INIT_EN
      if (state_q == INIT) begin
        if (initAddr_q == ADDR_W'(DEPTH - 1)) begin
          state_q    <= RUN;
          initDone_q <= 1'b1;
        end else begin
          initAddr_q <= initAddr_q + 1'b1;
        end
      end
`endif
    end
  end

  // FIFO storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clock) begin
    if (push) begin
      fifoMem_q[wrPtr_q] <= RW0_rdata;
    end
  end

endmodule

// File: tb/tb_array_17_port_driver.sv
// tb_array_17_port_driver
// ---------------------------------------------------------------------------
// Bench for array_17_port_driver. Contains a behavioural model of the
// 4096x80 byte-masked array driven by the DUT's RW0 port, plus an independent
// shadow copy of the expected array contents maintained from the requests the
// bench issues. Read expectations are queued at accept time and compared when
// the DUT hands out a response.
// ---------------------------------------------------------------------------
module tb_array_17_port_driver;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 80;
  localparam int MASK_W = 10;
  localparam int DEPTH  = 4096;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [MASK_W-1:0] req_mask;
  logic [DATA_W-1:0] req_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              init_done;
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [MASK_W-1:0] RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  logic [DATA_W-1:0] arrayMem [DEPTH];
  logic [DATA_W-1:0] shadow   [DEPTH];
  logic [DATA_W-1:0] expQ     [$];
  int                popCycles[$];

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int enCount = 0;

  always #5 clock = ~clock;

  array_17_port_driver #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .DEPTH(DEPTH)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_mask  (req_mask),
    .req_data  (req_data),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .init_done (init_done),
    .RW0_addr  (RW0_addr),
    .RW0_en    (RW0_en),
    .RW0_wmode (RW0_wmode),
    .RW0_wmask (RW0_wmask),
    .RW0_wdata (RW0_wdata),
    .RW0_rdata (RW0_rdata)
  );

  // Array model: byte-masked write, registered-address read.
  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) begin
        for (int b = 0; b < MASK_W; b++) begin
          if (RW0_wmask[b]) arrayMem[RW0_addr][b*8 +: 8] <= RW0_wdata[b*8 +: 8];
        end
      end else begin
        RW0_rdata <= arrayMem[RW0_addr];
      end
    end
  end

  always @(posedge clock) cyc++;

  function automatic logic [DATA_W-1:0] pattern(input int i);
    return {16'hC0DE, 32'(i * 7919), 32'(i) ^ 32'h5A5A_0000};
  endfunction

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: a response leaves the FIFO when valid and ready meet.
  always @(negedge clock) begin
    if (reset_n && RW0_en) enCount++;
    if (reset_n && resp_valid && resp_ready) begin
      popCycles.push_back(cyc);
      if (expQ.size() == 0) checkOutput("unexpected_resp_valid", 80'(resp_valid), 80'(0));
      else checkOutput("resp_data", resp_data, expQ.pop_front());
    end
  end

  // Drives one request starting just after a rising edge, waits (bounded)
  // for acceptance, records the expected effect and returns after the edge.
  task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] a,
                               input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d,
                               output int waited, output int acceptCyc);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_mask  = m;
    req_data  = d;
    waited    = 0;
    @(negedge clock);
    while (!req_ready && waited < 50) begin
      waited++;
      @(negedge clock);
    end
    checkOutput("req_ready_at_issue", 80'(req_ready), 80'(1));
    checkOutput("rw0_en_on_accept", 80'(RW0_en), 80'(1));
    checkOutput("rw0_addr_on_accept", 80'(RW0_addr), 80'(a));
    checkOutput("rw0_wmode_on_accept", 80'(RW0_wmode), 80'(wr));
    acceptCyc = cyc;
    if (wr) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (m[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
      end
    end else begin
      expQ.push_back(shadow[a]);
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

`ifdef ARRAY_17_PORT_INIT_EN
  // Follows a sweep from just after reset release until init_done rises.
  task automatic watchInitSweep();
    int zeroWrites = 0;
    int readyHigh  = 0;
    int budget     = 0;
    #1;
    while (!init_done && budget < 5000) begin
      if (RW0_en && RW0_wmode && RW0_wmask == '1 && RW0_wdata == '0) zeroWrites++;
      if (req_ready) readyHigh++;
      budget++;
      @(negedge clock);
      #1;
    end
    checkOutput("init_zero_writes", 80'(zeroWrites), 80'(DEPTH));
    checkOutput("init_req_ready_low", 80'(readyHigh), 80'(0));
    checkOutput("init_done_rises", 80'(init_done), 80'(1));
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
  endtask
`endif

  initial begin
    int w, ac, acc, budget, lat;
    logic took;

    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_mask   = '0;
    req_data   = '0;
    resp_ready = 1'b1;
    reset_n    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      arrayMem[i] = pattern(i);
      shadow[i]   = pattern(i);
    end

    // Reset state
    #12;
    checkOutput("reset_resp_valid", 80'(resp_valid), 80'(0));
    checkOutput("reset_rw0_en", 80'(RW0_en), 80'(0));
`ifdef ARRAY_17_PORT_INIT_EN
    checkOutput("reset_init_done", 80'(init_done), 80'(0));
    checkOutput("reset_req_ready", 80'(req_ready), 80'(0));
`else
    checkOutput("reset_init_done", 80'(init_done), 80'(1));
    checkOutput("reset_req_ready", 80'(req_ready), 80'(1));
`endif
    @(negedge clock);
    reset_n = 1'b1;
`ifdef ARRAY_17_PORT_INIT_EN
    watchInitSweep();
    @(posedge clock);
    #1;
    applyStimulus(1'b0, 12'hFFF, '0, '0, w, ac);
    repeat (4) @(posedge clock);
    #1;
`else
    @(posedge clock);
    #1;
`endif

    // Full write then read-after-write; response 2 cycles after accept
    applyStimulus(1'b1, 12'h123, 10'h3FF, 80'h0123_4567_89AB_CDEF_0011, w, ac);
    popCycles.delete();
    applyStimulus(1'b0, 12'h123, '0, '0, w, ac);
    repeat (4) @(posedge clock);
    #1;
    lat = (popCycles.size() > 0) ? popCycles[0] - ac : -1;
    checkOutput("read_latency", 80'(lat), 80'(2));

    // Single-byte overwrite keeps the upper nine bytes
    applyStimulus(1'b1, 12'h123, 10'h001, 80'hAB, w, ac);
    applyStimulus(1'b0, 12'h123, '0, '0, w, ac);
    repeat (4) @(posedge clock);
    #1;

    // Eight back-to-back reads with the consumer always ready
    popCycles.delete();
    enCount = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, ADDR_W'(i), '0, '0, w, ac);
      checkOutput("b2b_no_stall", 80'(w), 80'(0));
    end
    repeat (5) @(posedge clock);
    #1;
    checkOutput("b2b_resp_count", 80'(popCycles.size()), 80'(8));
    lat = (popCycles.size() == 8) ? popCycles[7] - popCycles[0] : -1;
    checkOutput("b2b_consecutive", 80'(lat), 80'(7));
    checkOutput("b2b_rw0_en_count", 80'(enCount), 80'(8));

    // Backpressure: continuous reads with the consumer stalled
    resp_ready = 1'b0;
    acc        = 0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 12'h040;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      took = req_ready;
      if (took) begin
        expQ.push_back(shadow[req_addr]);
        acc++;
      end
      @(posedge clock);
      #1;
      if (took) req_addr = req_addr + 1'b1;
    end
    @(negedge clock);
    checkOutput("stall_accept_count", 80'(acc), 80'(3));
    checkOutput("stall_req_ready", 80'(req_ready), 80'(0));
    checkOutput("stall_rw0_en", 80'(RW0_en), 80'(0));
    @(posedge clock);
    #1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    budget     = 0;
    while (expQ.size() > 0 && budget < 20) begin
      @(posedge clock);
      budget++;
    end
    #1;
    checkOutput("stall_drain", 80'(expQ.size()), 80'(0));
    applyStimulus(1'b0, 12'h005, '0, '0, w, ac);
    checkOutput("resume_no_stall", 80'(w), 80'(0));
    repeat (4) @(posedge clock);
    #1;

    // Reset with two queued responses and one read in flight
    resp_ready = 1'b0;
    applyStimulus(1'b0, 12'h020, '0, '0, w, ac);
    applyStimulus(1'b0, 12'h021, '0, '0, w, ac);
    applyStimulus(1'b0, 12'h022, '0, '0, w, ac);
    #1;
    checkOutput("pre_reset_resp_valid", 80'(resp_valid), 80'(1));
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("reset_resp_valid_async", 80'(resp_valid), 80'(0));
    expQ.delete();
    @(negedge clock);
    @(negedge clock);
    reset_n    = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checkOutput("no_stale_resp", 80'(resp_valid), 80'(0));
    end
`ifdef ARRAY_17_PORT_INIT_EN
    budget = 0;
    while (!init_done && budget < 5000) begin
      @(negedge clock);
      budget++;
    end
    checkOutput("reinit_done", 80'(init_done), 80'(1));
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
`endif
    @(posedge clock);
    #1;
    applyStimulus(1'b0, 12'h021, '0, '0, w, ac);
    budget = 0;
    while (expQ.size() > 0 && budget < 20) begin
      @(posedge clock);
      budget++;
    end
    #1;
    checkOutput("final_drain", 80'(expQ.size()), 80'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
